// File: rtl/penalty_referee_pkg.sv
// Shared definitions for the penalty referee.
//   state_t  : FSM state encoding (3-bit, IDLE..DONE)
//   WIN_*    : winner output codes
//   N3 / N5  : regulation kick counts per team
package penalty_referee_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REG_A = 3'd1,
    S_REG_B = 3'd2,
    S_SD_A  = 3'd3,
    S_SD_B  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_A     = 2'b01;
  localparam logic [1:0] WIN_B     = 2'b10;
  localparam logic [1:0] WIN_ABORT = 2'b11;

  localparam int unsigned N3 = 3;
  localparam int unsigned N5 = 5;

endpackage

// File: rtl/referee_decide.sv
// Combinational match-decision logic, evaluated on post-kick values.
// Ports:
//   score_a/score_b  : post-kick goal counts
//   kicks_a/kicks_b  : post-kick regulation kick counts
//   n_reg            : regulation length (3 or 5)
//   sd_round         : 1 = end of a sudden-death round, 0 = regulation kick
//   done_next        : match is decided by this kick
//   winner_next      : winner code to register when done_next is set
//   go_sudden        : regulation ended level, enter sudden death
module referee_decide
  import penalty_referee_pkg::*;
#(
  parameter int unsigned SCORE_W = 4,
  parameter int unsigned KICK_W  = 3
) (
  input  logic [SCORE_W-1:0] score_a,
  input  logic [SCORE_W-1:0] score_b,
  input  logic [KICK_W-1:0]  kicks_a,
  input  logic [KICK_W-1:0]  kicks_b,
  input  logic [KICK_W-1:0]  n_reg,
  input  logic               sd_round,
  output logic               done_next,
  output logic [1:0]         winner_next,
  output logic               go_sudden
);

  // Extended width so score + remaining kicks cannot overflow.
  localparam int unsigned EW = ((SCORE_W > KICK_W) ? SCORE_W : KICK_W) + 2;

  logic [EW-1:0] sa;
  logic [EW-1:0] sb;
  logic [EW-1:0] rem_a;
  logic [EW-1:0] rem_b;

  always_comb begin
    sa          = EW'(score_a);
    sb          = EW'(score_b);
    rem_a       = EW'(n_reg) - EW'(kicks_a);
    rem_b       = EW'(n_reg) - EW'(kicks_b);
    done_next   = 1'b0;
    winner_next = WIN_NONE;
    go_sudden   = 1'b0;
    if (sd_round) begin
      if (score_a > score_b) begin
        done_next   = 1'b1;
        winner_next = WIN_A;
      end else if (score_b > score_a) begin
        done_next   = 1'b1;
        winner_next = WIN_B;
      end else if (score_a == '1) begin
        // Both saturated and level: no further kick can separate them.
        done_next   = 1'b1;
        winner_next = WIN_ABORT;
      end
    end else begin
      if (sa > sb + rem_b) begin
        done_next   = 1'b1;
        winner_next = WIN_A;
      end else if (sb > sa + rem_a) begin
        done_next   = 1'b1;
        winner_next = WIN_B;
      end else if (kicks_a == n_reg && kicks_b == n_reg) begin
        // With no kicks remaining and no early finish, scores are level.
        go_sudden = 1'b1;
      end
    end
  end

endmodule

// File: rtl/penalty_referee.sv
// Penalty shoot-out referee: counts kicks and goals for two alternating
// teams, finishes early once decided, runs sudden death after a tie.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, mode5      : begin/restart pulse; 5 (1) or 3 (0) regulation kicks
//   kick_valid, goal  : one resolved kick and whether it scored
//   turn              : team to kick next (0 = A, 1 = B)
//   kicks_a/kicks_b   : regulation kicks taken
//   score_a/score_b   : goals (saturating)
//   sudden, done      : sudden-death flag, match-decided level
//   winner            : 00 none, 01 A, 10 B, 11 abort
module penalty_referee
  import penalty_referee_pkg::*;
#(
  parameter int unsigned SCORE_W = 4,
  parameter int unsigned KICK_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode5,
  input  logic               kick_valid,
  input  logic               goal,
  output logic               turn,
  output logic [KICK_W-1:0]  kicks_a,
  output logic [KICK_W-1:0]  kicks_b,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               sudden,
  output logic               done,
  output logic [1:0]         winner
);

  state_t             state, state_n;
  logic [KICK_W-1:0]  n_reg, n_reg_n;
  logic               turn_n;
  logic [KICK_W-1:0]  kicks_a_n, kicks_b_n;
  logic [SCORE_W-1:0] score_a_n, score_b_n;
  logic               sudden_n, done_n;
  logic [1:0]         winner_n;

  // Post-kick values fed to the decision logic.
  logic [KICK_W-1:0]  post_ka, post_kb;
  logic [SCORE_W-1:0] post_sa, post_sb;
  logic               dec_done, dec_sudden;
  logic [1:0]         dec_winner;

  always_comb begin
    post_ka = kicks_a;
    post_kb = kicks_b;
    post_sa = score_a;
    post_sb = score_b;
    if (kick_valid) begin
      if (state == S_REG_A) post_ka = kicks_a + KICK_W'(1);
      if (state == S_REG_B) post_kb = kicks_b + KICK_W'(1);
      if (goal && (state == S_REG_A || state == S_SD_A) && score_a != '1)
        post_sa = score_a + SCORE_W'(1);
      if (goal && (state == S_REG_B || state == S_SD_B) && score_b != '1)
        post_sb = score_b + SCORE_W'(1);
    end
  end

  referee_decide #(
    .SCORE_W (SCORE_W),
    .KICK_W  (KICK_W)
  ) u_decide (
    .score_a     (post_sa),
    .score_b     (post_sb),
    .kicks_a     (post_ka),
    .kicks_b     (post_kb),
    .n_reg       (n_reg),
    .sd_round    (state == S_SD_B),
    .done_next   (dec_done),
    .winner_next (dec_winner),
    .go_sudden   (dec_sudden)
  );

  always_comb begin
    state_n   = state;
    n_reg_n   = n_reg;
    turn_n    = turn;
    kicks_a_n = kicks_a;
    kicks_b_n = kicks_b;
    score_a_n = score_a;
    score_b_n = score_b;
    sudden_n  = sudden;
    done_n    = done;
    winner_n  = winner;
    if (start) begin
      // Restart from any state; a coincident kick is dropped.
      state_n   = S_REG_A;
      n_reg_n   = mode5 ? KICK_W'(N5) : KICK_W'(N3);
      turn_n    = 1'b0;
      kicks_a_n = '0;
      kicks_b_n = '0;
      score_a_n = '0;
      score_b_n = '0;
      sudden_n  = 1'b0;
      done_n    = 1'b0;
      winner_n  = WIN_NONE;
    end else if (kick_valid) begin
      unique case (state)
        S_REG_A, S_REG_B: begin
          kicks_a_n = post_ka;
          kicks_b_n = post_kb;
          score_a_n = post_sa;
          score_b_n = post_sb;
          turn_n    = ~turn;
          if (dec_done) begin
            state_n  = S_DONE;
            done_n   = 1'b1;
            winner_n = dec_winner;
          end else if (dec_sudden) begin
            state_n  = S_SD_A;
            sudden_n = 1'b1;
          end else begin
            state_n = (state == S_REG_A) ? S_REG_B : S_REG_A;
          end
        end
        S_SD_A: begin
          score_a_n = post_sa;
          turn_n    = 1'b1;
          state_n   = S_SD_B;
        end
        S_SD_B: begin
          score_b_n = post_sb;
          turn_n    = 1'b0;
          if (dec_done) begin
            state_n  = S_DONE;
            sudden_n = 1'b0;
            done_n   = 1'b1;
            winner_n = dec_winner;
          end else begin
            state_n = S_SD_A;
          end
        end
        default: ;  // IDLE and DONE ignore kicks
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      n_reg   <= '0;
      turn    <= 1'b0;
      kicks_a <= '0;
      kicks_b <= '0;
      score_a <= '0;
      score_b <= '0;
      sudden  <= 1'b0;
      done    <= 1'b0;
      winner  <= WIN_NONE;
    end else begin
      state   <= state_n;
      n_reg   <= n_reg_n;
      turn    <= turn_n;
      kicks_a <= kicks_a_n;
      kicks_b <= kicks_b_n;
      score_a <= score_a_n;
      score_b <= score_b_n;
      sudden  <= sudden_n;
      done    <= done_n;
      winner  <= winner_n;
    end
  end

endmodule
